// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO and its storage.
package fifo_pkg;

  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic full;
    logic empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Pointer width carries one extra wrap bit above the RAM address.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port; read latency 1.
// No backpressure: caller gates we/re, read register resets to zero, array does not.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read/write returns the old word, which is what a full FIFO needs.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered data_out and flags; read latency 1, no fall-through.
// Writes when full (without re) and reads when empty are dropped and flagged one cycle later.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] data_in,
  input  logic              re,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr, count_q, count_nxt;
  fifo_status_t     st_q;
  logic             do_wr, do_rd;

  // A read frees the head slot, so a write alongside it is accepted even when full.
  always_comb begin
    do_wr     = we && (!st_q.full || re);
    do_rd     = re && !st_q.empty;
    count_nxt = count_q + PTR_W'(do_wr) - PTR_W'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      st_q.full      <= 1'b0;
      st_q.empty     <= 1'b1;
      st_q.overflow  <= 1'b0;
      st_q.underflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q        <= count_nxt;
      st_q.full      <= (count_nxt == FULL_CNT);
      st_q.empty     <= (count_nxt == '0);
      st_q.overflow  <= we && st_q.full && !re;
      st_q.underflow <= re && st_q.empty;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (do_wr),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (do_rd),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (data_out)
  );

  assign full      = st_q.full;
  assign empty     = st_q.empty;
  assign count     = count_q;
  assign overflow  = st_q.overflow;
  assign underflow = st_q.underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and randomized stimulus for sync_fifo, checked every cycle against a queue model.
module tb_sync_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              we = 1'b0;
  logic              re = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              full, empty, overflow, underflow;
  logic [ADDR_W:0]   count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DATA_W-1:0] mdl_q[$];
  logic [DATA_W-1:0] mdl_dout = '0;
  logic              mdl_ovf  = 1'b0;
  logic              mdl_unf  = 1'b0;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .data_in   (data_in),
    .re        (re),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Applies one cycle of inputs, advances the model by the FIFO rules, then compares.
  task automatic step(input logic r, input logic w, input logic rd, input logic [DATA_W-1:0] d);
    bit was_full, was_empty;
    reset = r; we = w; re = rd; data_in = d;
    @(posedge clk);
    #1;
    was_full  = (mdl_q.size() == DEPTH);
    was_empty = (mdl_q.size() == 0);
    if (r) begin
      mdl_q.delete();
      mdl_dout = '0;
      mdl_ovf  = 1'b0;
      mdl_unf  = 1'b0;
    end else begin
      mdl_ovf = w && was_full && !rd;
      mdl_unf = rd && was_empty;
      if (rd && !was_empty) mdl_dout = mdl_q.pop_front();
      if (w && (!was_full || rd)) mdl_q.push_back(d);
    end
    chk("data_out",  data_out, mdl_dout);
    chk("count",     DATA_W'(count), DATA_W'(mdl_q.size()));
    chk("full",      DATA_W'(full),  DATA_W'(mdl_q.size() == DEPTH));
    chk("empty",     DATA_W'(empty), DATA_W'(mdl_q.size() == 0));
    chk("overflow",  DATA_W'(overflow),  DATA_W'(mdl_ovf));
    chk("underflow", DATA_W'(underflow), DATA_W'(mdl_unf));
    chk("not_full_and_empty", DATA_W'(full && empty), '0);
  endtask

  initial begin
    int pw, pr;
    logic [DATA_W-1:0] seq;

    // Reset held two cycles with both requests asserted.
    step(1, 1, 1, 32'h1234_5678);
    step(1, 1, 1, 32'h1234_5678);

    // Fill 0x1..0x10, then drain in order.
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, DATA_W'(i));
    chk("fill_full", DATA_W'(full), 1);
    chk("fill_count", DATA_W'(count), DEPTH);

    // Overflow while full: write dropped.
    step(0, 1, 0, 32'hDEAD_BEEF);
    chk("ovf_pulse", DATA_W'(overflow), 1);
    step(0, 0, 0, '0);
    chk("ovf_cleared", DATA_W'(overflow), 0);

    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 0, 1, '0);
      chk("drain_order", data_out, DATA_W'(i));
    end
    chk("drain_empty", DATA_W'(empty), 1);

    // Underflow: plain read, then read+write while empty.
    step(0, 0, 1, '0);
    chk("unf_hold", data_out, DATA_W'(DEPTH));
    step(0, 1, 1, 32'hA5A5_A5A5);
    chk("unf_rw_pulse", DATA_W'(underflow), 1);
    step(0, 0, 1, '0);
    chk("unf_next_read", data_out, 32'hA5A5_A5A5);

    // Simultaneous read/write at full across pointer wrap.
    seq = 32'h100;
    for (int i = 0; i < DEPTH; i++) begin step(0, 1, 0, seq); seq++; end
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, seq); seq++;
      chk("rw_full_count", DATA_W'(count), DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0);

    // Reset mid-stream with 5 entries stored.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'hC0 + DATA_W'(i));
    step(1, 0, 0, '0);
    chk("mid_reset_empty", DATA_W'(empty), 1);
    step(0, 1, 0, 32'h77);
    step(0, 0, 1, '0);
    chk("post_reset_read", data_out, 32'h77);

    // Randomized phases with varying read/write bias and rare resets.
    for (int p = 0; p < 20; p++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) == 0,
             $urandom_range(0, 99) < pw,
             $urandom_range(0, 99) < pr,
             DATA_W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
